// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants, buffer entry type and PC helpers for the fetch stage
package inst_fetch_pkg;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One buffered instruction: the address it was fetched from and the word.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
   } fetch_entry_t;

   // Clear the byte-offset bits so every fetch address is word aligned.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~(XLEN'(INST_BYTES) - XLEN'(1));
   endfunction

   // Sequential successor; wraps modulo 2^XLEN.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INST_BYTES);
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction memory read bus between the fetch stage and instruction memory
// Signals:
//   imem_req_valid  fetch -> mem  read request valid
//   imem_req_ready  mem -> fetch  request accepted this cycle
//   imem_req_addr   fetch -> mem  word-aligned byte address
//   imem_resp_valid mem -> fetch  read data valid (in order, no backpressure)
//   imem_resp_data  mem -> fetch  instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [XLEN-1:0] imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of {pc, data} entries buffering fetched instructions
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write one entry at the tail
//   pop               drop the head entry
//   flush             empty the FIFO; overrides push and pop
//   head_data         entry at the head (undefined when empty)
//   count             number of valid entries, 0..DEPTH
module fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_entry_t           head_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop    = pop && (count != '0);
   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_push   = push && ((count != FULL_COUNT) || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, memory requests, in-order instruction buffer, redirect
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   imem                instruction memory read bus (master side)
//   redirect_valid/pc   single-cycle redirect to a new fetch PC (bits [1:0] ignored)
//   inst_valid/ready    handshake towards decode
//   inst, inst_pc       instruction word and its address
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   inst_fetch_if.master    imem,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] redirect_target;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_count;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     occupancy;
   logic            pop;
   logic            accept;
   logic            resp;
   logic            push;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

   assign redirect_target = align_pc(redirect_pc);

   assign inst_valid = (fifo_count != '0) && !redirect_valid;
   assign pop        = inst_valid && inst_ready;

   // Every request still unanswered plus every buffered word must fit the
   // FIFO, so a returning response never finds it full.
   assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};

   assign imem.imem_req_valid = !reset && !redirect_valid && (occupancy < DEPTH_LIMIT);
   assign imem.imem_req_addr  = fetch_pc;

   assign accept = imem.imem_req_valid && imem.imem_req_ready;
   assign resp   = imem.imem_resp_valid;
   // Responses to requests issued before a redirect are counted off by drop_count.
   assign push   = resp && !redirect_valid && (drop_count == '0);

   assign push_entry.pc   = resp_pc;
   assign push_entry.data = imem.imem_resp_data;

   assign inst    = (fifo_count != '0) ? head_entry.data : '0;
   assign inst_pc = (fifo_count != '0) ? head_entry.pc   : '0;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head_data (head_entry),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_count  <= '0;
      end else begin
         case ({accept, resp})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase

         if (redirect_valid) begin
            fetch_pc   <= redirect_target;
            resp_pc    <= redirect_target;
            // Everything in flight after this cycle belongs to the old stream.
            drop_count <= outstanding - CW'(resp);
         end else begin
            if (accept) begin
               fetch_pc <= next_pc(fetch_pc);
            end
            if (resp) begin
               if (drop_count != '0) begin
                  drop_count <= drop_count - 1'b1;
               end else begin
                  resp_pc <= next_pc(resp_pc);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with an in-order memory model and stream scoreboard
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   inst_fetch_if imem ();

   inst_fetch #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem           (imem),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mem_req_t;

   mem_req_t    mem_q[$];
   mem_req_t    cur_resp;
   logic        cur_resp_valid;
   int          mem_lat;
   int          last_due;
   int          cycle;
   int          epoch;
   int          buffered;
   logic [31:0] exp_pc;
   logic [31:0] exp_req;

   int n_checks;
   int n_errors;

   logic        s_req_valid, s_acc, s_inst_valid, s_hs;
   logic [31:0] s_req_addr, s_inst, s_inst_pc;

   // One clock cycle: sample at the falling edge, score against the stream
   // model, then let the memory model present the next cycle's response.
   task automatic tick();
      int  outst;
      int  pop_m;
      logic exp_iv, exp_rv;
      mem_req_t e;
      @(negedge clk);
      s_req_valid  = imem.imem_req_valid;
      s_req_addr   = imem.imem_req_addr;
      s_inst_valid = inst_valid;
      s_inst       = inst;
      s_inst_pc    = inst_pc;
      s_hs         = inst_valid && inst_ready;
      s_acc        = imem.imem_req_valid && imem.imem_req_ready;
      if (reset) begin
         mem_q.delete();
         cur_resp_valid = 1'b0;
         buffered = 0;
         last_due = 0;
         exp_pc   = RESET_PC;
         exp_req  = RESET_PC;
         epoch++;
      end else begin
         outst  = mem_q.size() + (cur_resp_valid ? 1 : 0);
         exp_iv = (buffered > 0) && !redirect_valid;
         pop_m  = (exp_iv && inst_ready) ? 1 : 0;
         exp_rv = !redirect_valid && ((outst + buffered - pop_m) < DEPTH);
         n_checks++;
         if (s_inst_valid !== exp_iv) begin
            n_errors++;
            $display("FAIL model_inst_valid cyc=%0d: got %b expected %b", cycle, s_inst_valid, exp_iv);
         end
         n_checks++;
         if (s_req_valid !== exp_rv) begin
            n_errors++;
            $display("FAIL model_req_valid cyc=%0d: got %b expected %b", cycle, s_req_valid, exp_rv);
         end
         if (s_hs === 1'b1) begin
            n_checks++;
            if (s_inst_pc !== exp_pc || s_inst !== (exp_pc ^ DATA_KEY)) begin
               n_errors++;
               $display("FAIL model_deliver cyc=%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                        cycle, s_inst_pc, s_inst, exp_pc, exp_pc ^ DATA_KEY);
            end
            exp_pc = exp_pc + 32'd4;
            if (buffered > 0) buffered--;
         end
         if (s_acc === 1'b1) begin
            n_checks++;
            if (s_req_addr !== exp_req) begin
               n_errors++;
               $display("FAIL model_req_addr cyc=%0d: got %h expected %h", cycle, s_req_addr, exp_req);
            end
            e.addr  = s_req_addr;
            e.epoch = epoch;
            e.due   = (cycle + mem_lat > last_due) ? cycle + mem_lat : last_due;
            last_due = e.due;
            mem_q.push_back(e);
            exp_req = exp_req + 32'd4;
         end
         if (redirect_valid) begin
            epoch++;
            exp_pc   = redirect_pc & 32'hFFFF_FFFC;
            exp_req  = redirect_pc & 32'hFFFF_FFFC;
            buffered = 0;
         end else if (cur_resp_valid && cur_resp.epoch == epoch) begin
            buffered++;
         end
      end
      @(posedge clk);
      #1;
      cycle++;
      if (!reset && mem_q.size() > 0 && mem_q[0].due <= cycle) begin
         cur_resp = mem_q.pop_front();
         cur_resp_valid = 1'b1;
         imem.imem_resp_valid = 1'b1;
         imem.imem_resp_data  = cur_resp.addr ^ DATA_KEY;
      end else begin
         cur_resp_valid = 1'b0;
         imem.imem_resp_valid = 1'b0;
         imem.imem_resp_data  = $urandom;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      n_checks++;
      if (s_req_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_req_valid_during: got %b expected 0", s_req_valid);
      end
      tick();
      n_checks++;
      if (s_inst_valid !== 1'b0 || s_inst !== 32'h0 || s_inst_pc !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: got valid=%b inst=%h pc=%h expected 0/0/0", s_inst_valid, s_inst, s_inst_pc);
      end
      n_checks++;
      if (s_req_addr !== RESET_PC || s_req_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_req: got addr=%h valid=%b expected %h/0", s_req_addr, s_req_valid, RESET_PC);
      end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      logic [31:0] pc;
      mem_lat = 1;
      imem.imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         tick();
         if (i == 0) begin
            n_checks++;
            if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
               n_errors++;
               $display("FAIL stream_first_fetch: got valid=%b addr=%h expected 1/%h", s_req_valid, s_req_addr, RESET_PC);
            end
         end
         if (i < 2) begin
            n_checks++;
            if (s_inst_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL stream_early_valid c%0d: got %b expected 0", i, s_inst_valid);
            end
         end else begin
            pc = RESET_PC + 32'(4 * (i - 2));
            n_checks++;
            if (s_hs !== 1'b1 || s_inst_pc !== pc || s_inst !== (pc ^ DATA_KEY)) begin
               n_errors++;
               $display("FAIL stream_c%0d: got hs=%b pc=%h inst=%h expected 1/%h/%h", i, s_hs, s_inst_pc, s_inst, pc, pc ^ DATA_KEY);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int acc;
      mem_lat = 1;
      imem.imem_req_ready = 1'b1;
      inst_ready = 1'b0;
      do_reset();
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (s_acc) acc++;
      end
      n_checks++;
      if (acc !== DEPTH || s_req_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_stall: got accepted=%0d req_valid=%b expected %0d/0", acc, s_req_valid, DEPTH);
      end
      inst_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (s_hs !== 1'b1 || s_inst_pc !== RESET_PC + 32'(4 * k)) begin
            n_errors++;
            $display("FAIL bp_release_%0d: got hs=%b pc=%h expected 1/%h", k, s_hs, s_inst_pc, RESET_PC + 32'(4 * k));
         end
      end
   endtask

   task automatic wait_hs(input string name, input logic [31:0] pc);
      int n;
      n = 0;
      while (!s_hs && n < 30) begin
         tick();
         n++;
      end
      n_checks++;
      if (s_hs !== 1'b1 || s_inst_pc !== pc || s_inst !== (pc ^ DATA_KEY)) begin
         n_errors++;
         $display("FAIL %s: got hs=%b pc=%h inst=%h expected 1/%h/%h", name, s_hs, s_inst_pc, s_inst, pc, pc ^ DATA_KEY);
      end
   endtask

   task automatic test_redirect_inflight();
      mem_lat = 3;
      imem.imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_checks++;
      if (s_acc !== 1'b1 || s_req_addr !== 32'h100) begin
         n_errors++;
         $display("FAIL redir_next_req: got acc=%b addr=%h expected 1/00000100", s_acc, s_req_addr);
      end
      wait_hs("redir_first_inst", 32'h0000_0100);
      for (int i = 0; i < 6; i++) tick();
      n_checks++;
      if (dut.drop_count !== '0) begin
         n_errors++;
         $display("FAIL redir_drop_count: got %0d expected 0", dut.drop_count);
      end
   endtask

   task automatic test_redirect_with_resp();
      logic [31:0] tgt;
      int n;
      mem_lat = 2;
      imem.imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      n = 0;
      while (imem.imem_resp_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      n_checks++;
      if (imem.imem_resp_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL redir_resp_setup: got resp_valid=%b expected 1", imem.imem_resp_valid);
      end
      tgt = 32'h0000_2000 | ($urandom & 32'h0000_0FF0);
      redirect_valid = 1'b1;
      redirect_pc = tgt;
      tick();
      redirect_valid = 1'b0;
      tick();
      wait_hs("redir_resp_first_inst", tgt);
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (dut.drop_count !== '0) begin
         n_errors++;
         $display("FAIL redir_resp_drop_count: got %0d expected 0", dut.drop_count);
      end
   endtask

   task automatic test_unaligned();
      mem_lat = 2;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_checks++;
      if (s_acc !== 1'b1 || s_req_addr !== 32'h100) begin
         n_errors++;
         $display("FAIL unaligned_req: got acc=%b addr=%h expected 1/00000100", s_acc, s_req_addr);
      end
      wait_hs("unaligned_inst", 32'h0000_0100);
   endtask

   task automatic test_wrap();
      mem_lat = 1;
      for (int i = 0; i < 3; i++) tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_checks++;
      if (s_acc !== 1'b1 || s_req_addr !== 32'hFFFF_FFFC) begin
         n_errors++;
         $display("FAIL wrap_req0: got acc=%b addr=%h expected 1/fffffffc", s_acc, s_req_addr);
      end
      tick();
      n_checks++;
      if (s_acc !== 1'b1 || s_req_addr !== 32'h0) begin
         n_errors++;
         $display("FAIL wrap_req1: got acc=%b addr=%h expected 1/00000000", s_acc, s_req_addr);
      end
      wait_hs("wrap_inst0", 32'hFFFF_FFFC);
      tick();
      n_checks++;
      if (s_hs !== 1'b1 || s_inst_pc !== 32'h0) begin
         n_errors++;
         $display("FAIL wrap_inst1: got hs=%b pc=%h expected 1/00000000", s_hs, s_inst_pc);
      end
   endtask

   task automatic test_reset_mid();
      mem_lat = 1;
      inst_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (s_inst_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL midreset_setup: got inst_valid=%b expected 1", s_inst_valid);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      inst_ready = 1'b1;
      tick();
      n_checks++;
      if (s_inst_valid !== 1'b0 || s_acc !== 1'b1 || s_req_addr !== RESET_PC) begin
         n_errors++;
         $display("FAIL midreset_after: got valid=%b acc=%b addr=%h expected 0/1/%h", s_inst_valid, s_acc, s_req_addr, RESET_PC);
      end
      wait_hs("midreset_first_inst", RESET_PC);
   endtask

   task automatic test_random();
      int hs;
      logic prev_redir;
      mem_lat = 1;
      do_reset();
      hs = 0;
      prev_redir = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
         imem.imem_req_ready = ($urandom_range(0, 3) != 0);
         inst_ready = ($urandom_range(0, 3) != 0);
         redirect_valid = !prev_redir && ($urandom_range(0, 31) == 0);
         redirect_pc = $urandom;
         prev_redir = redirect_valid;
         tick();
         if (s_hs) hs++;
      end
      redirect_valid = 1'b0;
      n_checks++;
      if (hs < 50) begin
         n_errors++;
         $display("FAIL random_progress: got %0d handshakes expected >= 50", hs);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      cycle = 0;
      epoch = 0;
      buffered = 0;
      last_due = 0;
      mem_lat = 1;
      cur_resp_valid = 1'b0;
      exp_pc = RESET_PC;
      exp_req = RESET_PC;
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      inst_ready = 1'b0;
      imem.imem_req_ready = 1'b1;
      imem.imem_resp_valid = 1'b0;
      imem.imem_resp_data = 32'h0;

      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_with_resp();
      test_unaligned();
      test_wrap();
      test_reset_mid();
      test_random();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
